bcd_operand_loader: RTL and testbench

BCD_OPERAND_LOADER -- requirements
Module: bcd_operand_loader

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_check.sv | 16 +
 rtl/bcd_operand_loader.sv | 153 +++++++++++++++
 tb/tb_bcd_operand_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD operand loader.
//   BCD_DIGIT_W : width of one packed BCD digit
//   BCD_MAX     : largest legal BCD digit value
//   load_state_t: loader FSM states
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2,
    ERROR   = 2'd3
  } load_state_t;

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational range check for a single BCD digit.
// Ports:
//   digit  : candidate digit
//   bad    : 1 when digit is not a legal BCD value (greater than BCD_MAX)
module bcd_digit_check
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic                   bad
);

  always_comb begin
    bad = (digit > BCD_MAX);
  end

endmodule

// File: rtl/bcd_operand_loader.sv
// Serial BCD operand loader: collects NDIG digits of A, then NDIG digits of B
// (most-significant first), latches a carry-in with the final B digit and
// presents the complete operand set to a downstream BCD adder with a
// valid/ready handshake. A non-BCD digit parks the loader in ERROR with a
// sticky err flag until clear or rst.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   dig_in        : one BCD digit, MSD first
//   dig_valid     : dig_in holds a digit
//   dig_ready     : loader can accept a digit this cycle
//   cin_in        : carry-in, sampled with the final B digit
//   clear         : synchronous abort and flush (highest priority)
//   a_out, b_out  : assembled packed-BCD operands
//   cin_out       : latched carry-in
//   op_valid      : operand set complete and held stable
//   op_ready      : downstream takes the operand set
//   err           : sticky non-BCD digit flag
module bcd_operand_loader
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BCD_DIGIT_W-1:0]          dig_in,
  input  logic                            dig_valid,
  output logic                            dig_ready,
  input  logic                            cin_in,
  input  logic                            clear,
  output logic [BCD_DIGIT_W*NDIG-1:0]     a_out,
  output logic [BCD_DIGIT_W*NDIG-1:0]     b_out,
  output logic                            cin_out,
  output logic                            op_valid,
  input  logic                            op_ready,
  output logic                            err
);

  localparam int unsigned W  = BCD_DIGIT_W * NDIG;
  localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  load_state_t     state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            cin_reg;
  logic [CW-1:0]   cnt;
  logic            op_valid_reg;
  logic            err_reg;

  logic            digit_bad;
  logic            last_digit;
  // Shift-in computed on a widened vector so the slice stays legal for NDIG=1.
  logic [W+3:0]    a_ext;
  logic [W+3:0]    b_ext;

  bcd_digit_check u_digit_check (
    .digit (dig_in),
    .bad   (digit_bad)
  );

  assign a_ext      = {a_reg, dig_in};
  assign b_ext      = {b_reg, dig_in};
  assign last_digit = (cnt == CNT_LAST);

  // Ready is a pure state decode so it never depends on dig_valid.
  always_comb begin
    dig_ready = (state == LOAD_A) || (state == LOAD_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD_A;
      a_reg        <= '0;
      b_reg        <= '0;
      cin_reg      <= 1'b0;
      cnt          <= '0;
      op_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else if (clear) begin
      state        <= LOAD_A;
      a_reg        <= '0;
      b_reg        <= '0;
      cin_reg      <= 1'b0;
      cnt          <= '0;
      op_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      unique case (state)
        LOAD_A: begin
          if (dig_valid) begin
            if (digit_bad) begin
              state   <= ERROR;
              err_reg <= 1'b1;
            end else begin
              a_reg <= a_ext[W-1:0];
              if (last_digit) begin
                cnt   <= '0;
                state <= LOAD_B;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
        end

        LOAD_B: begin
          if (dig_valid) begin
            if (digit_bad) begin
              state   <= ERROR;
              err_reg <= 1'b1;
            end else begin
              b_reg <= b_ext[W-1:0];
              if (last_digit) begin
                cnt          <= '0;
                cin_reg      <= cin_in;
                op_valid_reg <= 1'b1;
                state        <= PRESENT;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
        end

        PRESENT: begin
          if (op_ready) begin
            state        <= LOAD_A;
            a_reg        <= '0;
            b_reg        <= '0;
            cin_reg      <= 1'b0;
            cnt          <= '0;
            op_valid_reg <= 1'b0;
          end
        end

        ERROR: begin
          state <= ERROR;
        end

        default: begin
          state <= LOAD_A;
        end
      endcase
    end
  end

  assign a_out    = a_reg;
  assign b_out    = b_reg;
  assign cin_out  = cin_reg;
  assign op_valid = op_valid_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Directed self-checking bench for bcd_operand_loader (NDIG=2).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_bcd_operand_loader;

  logic       clk;
  logic       rst;
  logic [3:0] dig_in;
  logic       dig_valid;
  logic       dig_ready;
  logic       cin_in;
  logic       clear;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic       cin_out;
  logic       op_valid;
  logic       op_ready;
  logic       err;

  int unsigned checks;
  int unsigned errors;

  bcd_operand_loader #(.NDIG(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .dig_in    (dig_in),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .cin_in    (cin_in),
    .clear     (clear),
    .a_out     (a_out),
    .b_out     (b_out),
    .cin_out   (cin_out),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one valid digit for exactly one rising edge.
  task put_digit(input logic [3:0] d, input logic c);
    dig_in    = d;
    cin_in    = c;
    dig_valid = 1'b1;
    @(negedge clk);
    dig_valid = 1'b0;
    cin_in    = 1'b0;
  endtask

  task test_reset;
    #1;
    checks++; if (dig_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", dig_ready); end
    checks++; if ({a_out, b_out, cin_out, op_valid, err} !== 19'd0) begin errors++;
      $display("FAIL reset_outputs: a=%h b=%h cin=%b ov=%b err=%b want all 0", a_out, b_out, cin_out, op_valid, err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dig_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", dig_ready); end
  endtask

  task test_normal;
    op_ready = 1'b1;
    put_digit(4'd6, 1'b0);
    put_digit(4'd4, 1'b0);
    put_digit(4'd1, 1'b0);
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL normal_early_valid: got %b want 0", op_valid); end
    put_digit(4'd7, 1'b1);
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL normal_valid: got %b want 1", op_valid); end
    checks++; if (a_out !== 8'h64) begin errors++; $display("FAIL normal_a: got %h want 64", a_out); end
    checks++; if (b_out !== 8'h17) begin errors++; $display("FAIL normal_b: got %h want 17", b_out); end
    checks++; if (cin_out !== 1'b1) begin errors++; $display("FAIL normal_cin: got %b want 1", cin_out); end
    @(negedge clk);
    checks++; if (op_valid !== 1'b0 || dig_ready !== 1'b1 || a_out !== 8'h00) begin errors++;
      $display("FAIL normal_return: ov=%b rdy=%b a=%h want 0,1,00", op_valid, dig_ready, a_out); end
    op_ready = 1'b0;
  endtask

  task test_backpressure;
    op_ready = 1'b0;
    put_digit(4'd6, 1'b0);
    put_digit(4'd4, 1'b0);
    put_digit(4'd1, 1'b0);
    put_digit(4'd7, 1'b1);
    // Extra digits offered while presenting must be ignored.
    dig_in    = 4'd5;
    dig_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (op_valid !== 1'b1 || dig_ready !== 1'b0) begin errors++;
        $display("FAIL bp_hold_%0d: ov=%b rdy=%b want 1,0", i, op_valid, dig_ready); end
      checks++; if (a_out !== 8'h64 || b_out !== 8'h17 || cin_out !== 1'b1) begin errors++;
        $display("FAIL bp_stable_%0d: a=%h b=%h cin=%b want 64,17,1", i, a_out, b_out, cin_out); end
      @(negedge clk);
    end
    dig_valid = 1'b0;
    op_ready  = 1'b1;
    checks++; if (op_valid !== 1'b1 || a_out !== 8'h64) begin errors++;
      $display("FAIL bp_before_hs: ov=%b a=%h want 1,64", op_valid, a_out); end
    @(negedge clk);
    op_ready = 1'b0;
    checks++; if (op_valid !== 1'b0 || a_out !== 8'h00 || b_out !== 8'h00 || dig_ready !== 1'b1) begin errors++;
      $display("FAIL bp_after_hs: ov=%b a=%h b=%h rdy=%b want 0,00,00,1", op_valid, a_out, b_out, dig_ready); end
  endtask

  task test_invalid;
    put_digit(4'd3, 1'b0);
    put_digit(4'hA, 1'b0);
    checks++; if (err !== 1'b1 || dig_ready !== 1'b0) begin errors++;
      $display("FAIL inv_err: err=%b rdy=%b want 1,0", err, dig_ready); end
    checks++; if (a_out !== 8'h03) begin errors++; $display("FAIL inv_a: got %h want 03", a_out); end
    // ERROR is sticky: further digits and op_ready change nothing.
    op_ready = 1'b1;
    put_digit(4'd5, 1'b0);
    put_digit(4'd2, 1'b0);
    op_ready = 1'b0;
    checks++; if (err !== 1'b1 || a_out !== 8'h03 || op_valid !== 1'b0) begin errors++;
      $display("FAIL inv_sticky: err=%b a=%h ov=%b want 1,03,0", err, a_out, op_valid); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (err !== 1'b0 || dig_ready !== 1'b1) begin errors++;
      $display("FAIL inv_clear: err=%b rdy=%b want 0,1", err, dig_ready); end
    checks++; if ({a_out, b_out, cin_out, op_valid} !== 18'd0) begin errors++;
      $display("FAIL inv_clear_out: a=%h b=%h cin=%b ov=%b want 0", a_out, b_out, cin_out, op_valid); end
  endtask

  task test_clear_priority;
    op_ready = 1'b0;
    put_digit(4'd6, 1'b0);
    put_digit(4'd4, 1'b0);
    put_digit(4'd1, 1'b0);
    clear = 1'b1;
    put_digit(4'd7, 1'b1);
    clear = 1'b0;
    checks++; if (op_valid !== 1'b0 || dig_ready !== 1'b1) begin errors++;
      $display("FAIL clr_pri_state: ov=%b rdy=%b want 0,1", op_valid, dig_ready); end
    checks++; if (a_out !== 8'h00 || b_out !== 8'h00 || cin_out !== 1'b0) begin errors++;
      $display("FAIL clr_pri_regs: a=%h b=%h cin=%b want 00,00,0", a_out, b_out, cin_out); end
    // Counter must also be flushed: a fresh load lands on the right digits.
    put_digit(4'd2, 1'b0);
    put_digit(4'd3, 1'b0);
    put_digit(4'd4, 1'b0);
    put_digit(4'd5, 1'b0);
    checks++; if (op_valid !== 1'b1 || a_out !== 8'h23 || b_out !== 8'h45 || cin_out !== 1'b0) begin errors++;
      $display("FAIL clr_reload: ov=%b a=%h b=%h cin=%b want 1,23,45,0", op_valid, a_out, b_out, cin_out); end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
  endtask

  task test_async_reset;
    put_digit(4'd9, 1'b0);
    put_digit(4'd9, 1'b0);
    put_digit(4'd5, 1'b0);
    checks++; if (a_out !== 8'h99 || b_out !== 8'h05) begin errors++;
      $display("FAIL ar_partial: a=%h b=%h want 99,05", a_out, b_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_out !== 8'h00 || b_out !== 8'h00 || op_valid !== 1'b0 || dig_ready !== 1'b1) begin errors++;
      $display("FAIL ar_immediate: a=%h b=%h ov=%b rdy=%b want 00,00,0,1", a_out, b_out, op_valid, dig_ready); end
    #1 rst = 1'b0;
    @(negedge clk);
    put_digit(4'd1, 1'b0);
    put_digit(4'd2, 1'b0);
    put_digit(4'd3, 1'b0);
    put_digit(4'd4, 1'b0);
    checks++; if (op_valid !== 1'b1 || a_out !== 8'h12 || b_out !== 8'h34) begin errors++;
      $display("FAIL ar_reload: ov=%b a=%h b=%h want 1,12,34", op_valid, a_out, b_out); end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
  endtask

  task test_valid_gaps;
    logic [3:0] seq [4];
    seq[0] = 4'd0; seq[1] = 4'd9; seq[2] = 4'd9; seq[3] = 4'd0;
    for (int i = 0; i < 4; i++) begin
      put_digit(seq[i], 1'b0);
      if (i < 3) begin
        dig_in = 4'd7;   // junk on the idle cycle, must not be taken
        @(negedge clk);
      end
    end
    checks++; if (op_valid !== 1'b1 || a_out !== 8'h09 || b_out !== 8'h90 || cin_out !== 1'b0) begin errors++;
      $display("FAIL gaps: ov=%b a=%h b=%h cin=%b want 1,09,90,0", op_valid, a_out, b_out, cin_out); end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    checks++; if (op_valid !== 1'b0 || dig_ready !== 1'b1) begin errors++;
      $display("FAIL gaps_hs: ov=%b rdy=%b want 0,1", op_valid, dig_ready); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    dig_in    = 4'd0;
    dig_valid = 1'b0;
    cin_in    = 1'b0;
    clear     = 1'b0;
    op_ready  = 1'b0;

    test_reset();
    test_normal();
    test_backpressure();
    test_invalid();
    test_clear_priority();
    test_async_reset();
    test_valid_gaps();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
